draw_scroll_layer: RTL and testbench

Parametrised scrolling background-strip generator, successor to the fixed horizon drawer. It keeps a horizontal scroll position into a wide sprite strip stored in sprite ROM. The position advances once per frame strobe, and the scroll speed ramps up over time. The block also freezes on death and wraps correctly within each strip row. It produces the sprite-ROM address for the frame-buffer write side and window-hit flags for both the write side and the display (draw) side.

---
 rtl/draw_scroll_layer.sv | 98 +++++++++
 tb/tb_draw_scroll_layer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/draw_scroll_layer.sv
// Scrolling background strip: frame-driven scroll position with speed ramp and death
// freeze, plus registered sprite-ROM address and window-hit flags for write and draw sides.
module draw_scroll_layer #(
  parameter int unsigned           ADDR_W       = 18,
  parameter logic [ADDR_W-1:0]     BASE_ADDR    = ADDR_W'(85015),
  parameter int unsigned           STRIP_W      = 2400,
  parameter int unsigned           STRIP_H      = 24,
  parameter int unsigned           WIN_W        = 640,
  parameter int unsigned           POS_X        = 0,
  parameter int unsigned           POS_Y        = 400,
  parameter int unsigned           SPEED_INIT   = 4,
  parameter int unsigned           SPEED_MAX    = 12,
  parameter int unsigned           ACCEL_FRAMES = 600
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_strobe,
  input  logic                        Dead,
  input  logic [9:0]                  WriteX,
  input  logic [9:0]                  WriteY,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  output logic                        horizon_on_wr,
  output logic                        horizon_on_dr,
  output logic [ADDR_W-1:0]           address,
  output logic [$clog2(STRIP_W)-1:0]  scroll_pos,
  output logic [5:0]                  speed
);

  localparam int SW = $clog2(STRIP_W);
  localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int IW = (ADDR_W + 1 > 32) ? ADDR_W + 1 : 32;

  logic          fs_q;
  logic [CW-1:0] acc_cnt;
  logic          tick;
  logic          acc_last;
  logic [SW:0]   pos_sum;
  logic [SW:0]   pos_next;
  logic [5:0]    speed_next;

  assign tick       = frame_strobe & ~fs_q;
  assign acc_last   = (acc_cnt == CW'(ACCEL_FRAMES - 1));
  assign pos_sum    = {1'b0, scroll_pos} + (SW+1)'(speed);
  assign pos_next   = (pos_sum >= (SW+1)'(STRIP_W)) ? pos_sum - (SW+1)'(STRIP_W) : pos_sum;
  assign speed_next = (speed < 6'(SPEED_MAX)) ? speed + 6'd1 : speed;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs_q       <= 1'b0;
      scroll_pos <= '0;
      speed      <= 6'(SPEED_INIT);
      acc_cnt    <= '0;
    end else begin
      fs_q <= frame_strobe;
      if (tick && !Dead) begin
        scroll_pos <= SW'(pos_next);
        if (acc_last) begin
          acc_cnt <= '0;
          speed   <= speed_next;
        end else begin
          acc_cnt <= acc_cnt + CW'(1);
        end
      end
    end
  end

  // Offsets are formed wide so a coordinate left of/above the window wraps to a
  // huge value and fails the single upper-bound compare.
  logic [IW-1:0] wr_dx, wr_dy, dr_dx, dr_dy;
  logic          in_wr, in_dr;
  logic [IW-1:0] col_sum, col, addr_full;

  assign wr_dx = IW'(WriteX) - IW'(POS_X);
  assign wr_dy = IW'(WriteY) - IW'(POS_Y);
  assign dr_dx = IW'(DrawX)  - IW'(POS_X);
  assign dr_dy = IW'(DrawY)  - IW'(POS_Y);

  assign in_wr = (wr_dx < IW'(WIN_W)) && (wr_dy < IW'(STRIP_H));
  assign in_dr = (dr_dx < IW'(WIN_W)) && (dr_dy < IW'(STRIP_H));

  assign col_sum   = IW'(scroll_pos) + wr_dx;
  assign col       = (col_sum >= IW'(STRIP_W)) ? col_sum - IW'(STRIP_W) : col_sum;
  assign addr_full = IW'(BASE_ADDR) + wr_dy * IW'(STRIP_W) + col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      horizon_on_wr <= 1'b0;
      horizon_on_dr <= 1'b0;
      address       <= BASE_ADDR;
    end else begin
      horizon_on_wr <= in_wr;
      horizon_on_dr <= in_dr;
      address       <= in_wr ? ADDR_W'(addr_full) : BASE_ADDR;
    end
  end

endmodule

// File: tb/tb_draw_scroll_layer.sv
// Bench for draw_scroll_layer: three parameterisations driven in lockstep and
// compared every cycle against a frame-count based reference model.
module tb_draw_scroll_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fs, dead;
  logic [9:0] wx, wy, dxi, dyi;

  logic [11:0] pos_o[3];
  logic [5:0]  spd_o[3];
  logic [17:0] addr_o[3];
  logic        wr_o[3];
  logic        dr_o[3];

  draw_scroll_layer u0 (
    .Clk(clk), .Reset(rst), .frame_strobe(fs), .Dead(dead),
    .WriteX(wx), .WriteY(wy), .DrawX(dxi), .DrawY(dyi),
    .horizon_on_wr(wr_o[0]), .horizon_on_dr(dr_o[0]), .address(addr_o[0]),
    .scroll_pos(pos_o[0]), .speed(spd_o[0])
  );

  draw_scroll_layer #(.ACCEL_FRAMES(3), .SPEED_MAX(5)) u1 (
    .Clk(clk), .Reset(rst), .frame_strobe(fs), .Dead(dead),
    .WriteX(wx), .WriteY(wy), .DrawX(dxi), .DrawY(dyi),
    .horizon_on_wr(wr_o[1]), .horizon_on_dr(dr_o[1]), .address(addr_o[1]),
    .scroll_pos(pos_o[1]), .speed(spd_o[1])
  );

  draw_scroll_layer #(.ACCEL_FRAMES(10000)) u2 (
    .Clk(clk), .Reset(rst), .frame_strobe(fs), .Dead(dead),
    .WriteX(wx), .WriteY(wy), .DrawX(dxi), .DrawY(dyi),
    .horizon_on_wr(wr_o[2]), .horizon_on_dr(dr_o[2]), .address(addr_o[2]),
    .scroll_pos(pos_o[2]), .speed(spd_o[2])
  );

  int checks = 0;
  int errors = 0;

  int af[3]   = '{600, 3, 10000};
  int smax[3] = '{12, 5, 12};
  int m_pos[3];
  int m_n[3];
  bit m_fsq = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Speed is a pure function of how many live frames have elapsed.
  function automatic int m_speed(int k);
    int s;
    s = 4 + m_n[k] / af[k];
    return (s > smax[k]) ? smax[k] : s;
  endfunction

  function automatic bit in_win(int x, int y);
    return (x >= 0) && (x < 640) && (y >= 400) && (y < 424);
  endfunction

  task automatic cycle(input bit r, input bit f, input bit d,
                       input int x, input int y, input int ddx, input int ddy);
    int exp_addr[3];
    bit exp_wr, exp_dr;
    rst = r; fs = f; dead = d;
    wx = 10'(x); wy = 10'(y); dxi = 10'(ddx); dyi = 10'(ddy);
    exp_wr = !r && in_win(x, y);
    exp_dr = !r && in_win(ddx, ddy);
    for (int k = 0; k < 3; k++)
      exp_addr[k] = exp_wr ? 85015 + (y - 400) * 2400 + (m_pos[k] + x) % 2400 : 85015;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        m_pos[k] = 0;
        m_n[k]   = 0;
      end
      m_fsq = 1'b0;
    end else begin
      if (f && !m_fsq && !d) begin
        for (int k = 0; k < 3; k++) begin
          m_pos[k] = (m_pos[k] + m_speed(k)) % 2400;
          m_n[k]++;
        end
      end
      m_fsq = f;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pos%0d", k),  32'(pos_o[k]),  32'(m_pos[k]));
      check($sformatf("spd%0d", k),  32'(spd_o[k]),  32'(m_speed(k)));
      check($sformatf("addr%0d", k), 32'(addr_o[k]), 32'(exp_addr[k]));
      check($sformatf("wr%0d", k),   32'(wr_o[k]),   32'(exp_wr));
      check($sformatf("dr%0d", k),   32'(dr_o[k]),   32'(exp_dr));
    end
  endtask

  task automatic tick_n(input int n, input bit d);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, d, 0, 0, 0, 0);
      cycle(1'b0, 1'b0, d, 0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 0;
      m_n[k]   = 0;
    end

    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    check("rst_pos",  32'(pos_o[0]),  32'd0);
    check("rst_spd",  32'(spd_o[0]),  32'd4);
    check("rst_addr", 32'(addr_o[0]), 32'd85015);
    check("rst_wr",   32'(wr_o[0]),   32'd0);

    tick_n(3, 1'b0);
    check("t3_pos",     32'(pos_o[0]), 32'd12);
    check("t3_spd",     32'(spd_o[0]), 32'd4);
    check("acc_t3_pos", 32'(pos_o[1]), 32'd12);
    check("acc_t3_spd", 32'(spd_o[1]), 32'd5);
    tick_n(1, 1'b0);
    check("acc_t4_pos", 32'(pos_o[1]), 32'd17);
    tick_n(3, 1'b0);
    check("acc_sat_spd", 32'(spd_o[1]), 32'd5);
    check("acc_t7_pos",  32'(pos_o[1]), 32'd32);

    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    tick_n(599, 1'b0);
    check("wrap_pre", 32'(pos_o[2]), 32'd2396);
    cycle(1'b0, 1'b0, 1'b0, 10, 400, 0, 0);
    check("wrap_addr", 32'(addr_o[2]), 32'd85021);
    check("wrap_wr",   32'(wr_o[2]),   32'd1);
    tick_n(1, 1'b0);
    check("wrap_pos", 32'(pos_o[2]), 32'd0);

    cycle(1'b0, 1'b0, 1'b0, 639, 423, 640, 410);
    check("bound_addr", 32'(addr_o[2]), 32'd140854);
    check("bound_wr",   32'(wr_o[2]),   32'd1);
    check("bound_dr",   32'(dr_o[2]),   32'd0);
    cycle(1'b0, 1'b0, 1'b0, 639, 424, 639, 410);
    check("below_wr",   32'(wr_o[2]),   32'd0);
    check("below_addr", 32'(addr_o[2]), 32'd85015);
    check("edge_dr",    32'(dr_o[2]),   32'd1);

    tick_n(5, 1'b1);
    check("dead_pos", 32'(pos_o[2]), 32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    check("hold_pos", 32'(pos_o[2]), 32'd4);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 700)), int'($urandom_range(380, 440)),
            int'($urandom_range(0, 700)), int'($urandom_range(380, 440)));
    end

    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    cycle(1'b1, 1'b1, 1'b0, 5, 405, 5, 405);
    check("rst_tick_pos",  32'(pos_o[0]),  32'd0);
    check("rst_tick_spd",  32'(spd_o[0]),  32'd4);
    check("rst_tick_wr",   32'(wr_o[0]),   32'd0);
    check("rst_tick_dr",   32'(dr_o[0]),   32'd0);
    check("rst_tick_addr", 32'(addr_o[0]), 32'd85015);
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    check("post_rst_tick", 32'(pos_o[0]), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
